ysyx_23060203_csr_file: RTL and testbench
=========================================

// Module: ysyx_23060203_csr_file
// PURPOSE
//  Machine-mode CSR file; the write-side target of the WBU CSR port (csr_wen/csr_waddr/csr_wdata).
//  Also serves a combinational read port for the EXU, trap-entry and mret side effects, and a free-running 64-bit mcycle.
//  Sits beside the GPR file. Owns all architectural CSR state.
// PARAMETERS
//  MVENDORID  32'h7973_7978  read-only mvendorid value ("ysyx")
//  MARCHID    32'h015F_DEEB  read-only marchid value (23060203 decimal)
//  MSTATUS_RV 32'h0000_1800  mstatus reset value (MPP=M, MIE=0, MPIE=0)
// PORTS
//  clock        in   1   system clock, all state on posedge
//  reset        in   1   asynchronous, active-low reset
//  csr_wen      in   1   write enable from WBU
//  csr_waddr    in   12  write address
//  csr_wdata    in   32  write data
//  csr_raddr    in   12  read address from EXU
//  csr_rdata    out  32  read data, combinational
//  trap_valid   in   1   ecall/exception commit this cycle
//  trap_pc      in   32  pc of trapping instruction
//  trap_cause   in   32  mcause value
//  mret_valid   in   1   mret commit this cycle
//  mtvec_o      out  32  current mtvec (trap target)
//  mepc_o       out  32  current mepc (mret target)
// BEHAVIOUR
//  - Implemented CSRs: mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342, mcycle 0xB00, mcycleh 0xB80, mvendorid 0xF11, marchid 0xF12.
//  - Reset (reset==0, async): mstatus=MSTATUS_RV, mtvec=mepc=mcause=0, mcycle=64'h0. Outputs reflect these immediately.
//  - Read: csr_rdata = current register value, 0 for unimplemented addrs. No write-to-read bypass; a same-cycle write is visible next cycle.
//  - Write: 1-cycle latency, applied on posedge when csr_wen. Writes to address 0x000 (ebreak marker) and read-only/unimplemented addrs are dropped silently.
//  - mstatus write mask 32'h0000_1888 (MIE bit3, MPIE bit7, MPP bits12:11); MPP is forced to 2'b11 regardless of wdata. mepc write clears bits[1:0].
//  - mcycle: +1 every cycle, wraps 2^64-1 -> 0 with carry into mcycleh. A write to 0xB00 replaces the low word and cancels that cycle's increment of both halves; a write to 0xB80 replaces the high word, and the low word still increments without carry.
//  - trap_valid: mepc<=trap_pc&~3, mcause<=trap_cause, mstatus.MPIE<=MIE, MIE<=0, MPP<=11.
//  - mret_valid: mstatus.MIE<=MPIE, MPIE<=1, MPP<=11.
//  - Priority per register in the same cycle: trap > mret > csr write. Writes to registers untouched by trap/mret still land.
//  - trap_valid and mret_valid together is illegal; an SVA assertion fires, and the trap is applied.
//  - mtvec_o/mepc_o are register outputs with no combinational path from inputs.
//  - Reset asserted mid-operation: all state returns to reset values; a pending write in that cycle is lost.
// STRUCTURE
//  - Shared package ysyx_23060203_pkg: CSR address localparams (CSR_MSTATUS...CSR_MARCHID), MSTATUS_WMASK, mstatus bit-index constants.
//  - One sub-module: ysyx_23060203_csr_cnt64 (64-bit counter, split hi/lo write, carry handling).
//  - Read mux is a unique case on csr_raddr.
// TESTING
//  1 Reset: reset low mid-run -> csr_rdata@0x300=0x1800, mtvec_o=0, mepc_o=0, mcycle=0.
//  2 Write 0x305<=0x8000_0100, then read 0x305 -> 0x8000_0100 next cycle. Same-cycle read returns the old value.
//  3 Write 0x000 and 0xF11<=0 -> no state change; 0xF11 still reads 0x7973_7978.
//  4 trap_valid with pc=0x8000_0024, cause=11, MIE=1 -> mepc=0x8000_0024, mcause=11, MIE=0, MPIE=1. Then mret -> MIE=1, MPIE=1.
//  5 Write mcycle<=0xFFFF_FFFF, then idle one cycle -> mcycle=0, mcycleh incremented by 1. Write 0xB00 in the same cycle as an increment -> the written value holds, no +1.
//  6 trap_valid plus csr write 0x341<=0x1234 in the same cycle -> mepc=trap_pc. Trap plus write 0x305 in the same cycle -> both applied.

Source files
------------

// File: rtl/ysyx_23060203_pkg.sv
// Purpose: CSR addresses, mstatus field positions and mstatus update helpers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package ysyx_23060203_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;

    // Only MIE, MPIE and MPP are writable; every other mstatus bit is hard zero.
    localparam logic [31:0] MSTATUS_WMASK = 32'h0000_1888;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    // Only M-mode exists, so MPP always reads back as M.
    function automatic logic [31:0] mstatus_force_mpp(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    // Trap entry: stash MIE into MPIE and mask interrupts.
    function automatic logic [31:0] mstatus_on_trap(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        r[MSTATUS_MPIE] = s[MSTATUS_MIE];
        r[MSTATUS_MIE]  = 1'b0;
        return mstatus_force_mpp(r);
    endfunction

    // mret: restore MIE from MPIE and set MPIE.
    function automatic logic [31:0] mstatus_on_mret(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        return mstatus_force_mpp(r);
    endfunction

endpackage

// File: rtl/ysyx_23060203_csr_cnt64.sv
// Purpose: free-running 64-bit cycle counter with independent 32-bit half writes.
// Latency: writes and increments land on the next posedge.
// Backpressure: none; always counts.
//
// Ports:
//   clock, reset   : clock and async active-low reset
//   wen_lo_i       : replace low word, both halves skip this cycle's increment
//   wen_hi_i       : replace high word, low word still increments (carry dropped)
//   wdata_i        : write data for either half
//   cnt_o          : current 64-bit count
module ysyx_23060203_csr_cnt64 (
    input  logic        clock,
    input  logic        reset,
    input  logic        wen_lo_i,
    input  logic        wen_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] cnt_o
);

    logic [31:0] lo_q, lo_d;
    logic [31:0] hi_q, hi_d;
    logic [32:0] lo_inc;

    always_comb begin
        lo_inc = {1'b0, lo_q} + 33'd1;
        lo_d   = lo_inc[31:0];
        hi_d   = hi_q + {31'b0, lo_inc[32]};
        if (wen_lo_i) begin
            lo_d = wdata_i;
            hi_d = hi_q;
        end else if (wen_hi_i) begin
            // High word is overwritten, so the low word's carry is discarded.
            hi_d = wdata_i;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lo_q <= 32'h0;
            hi_q <= 32'h0;
        end else begin
            lo_q <= lo_d;
            hi_q <= hi_d;
        end
    end

    assign cnt_o = {hi_q, lo_q};

endmodule

// File: rtl/ysyx_23060203_csr_file.sv
// Purpose: machine-mode CSR file with trap/mret side effects and a 64-bit mcycle.
// Latency: combinational read; writes, trap and mret effects visible after one posedge.
// Backpressure: none; every write, trap and mret is accepted in the cycle it is presented.
//
// Ports:
//   clock, reset                     : clock and async active-low reset
//   csr_wen/csr_waddr/csr_wdata      : WBU write port
//   csr_raddr/csr_rdata              : EXU read port (no write bypass)
//   trap_valid/trap_pc/trap_cause    : trap entry commit
//   mret_valid                       : mret commit
//   mtvec_o/mepc_o                   : registered trap/return targets
module ysyx_23060203_csr_file
    import ysyx_23060203_pkg::*;
#(
    parameter logic [31:0] MVENDORID  = 32'h7973_7978,
    parameter logic [31:0] MARCHID    = 32'h015F_DEEB,
    parameter logic [31:0] MSTATUS_RV = 32'h0000_1800
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        csr_wen,
    input  logic [11:0] csr_waddr,
    input  logic [31:0] csr_wdata,
    input  logic [11:0] csr_raddr,
    output logic [31:0] csr_rdata,
    input  logic        trap_valid,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_cause,
    input  logic        mret_valid,
    output logic [31:0] mtvec_o,
    output logic [31:0] mepc_o
);

    logic [31:0] mstatus_q, mstatus_d;
    logic [31:0] mtvec_q,   mtvec_d;
    logic [31:0] mepc_q,    mepc_d;
    logic [31:0] mcause_q,  mcause_d;
    logic [63:0] mcycle;

    // Read-only and unimplemented addresses (including the 0x000 ebreak
    // marker) simply never match a decode, so those writes fall away.
    logic wr_mstatus, wr_mtvec, wr_mepc, wr_mcause, wr_mcycle, wr_mcycleh;

    assign wr_mstatus = csr_wen && (csr_waddr == CSR_MSTATUS);
    assign wr_mtvec   = csr_wen && (csr_waddr == CSR_MTVEC);
    assign wr_mepc    = csr_wen && (csr_waddr == CSR_MEPC);
    assign wr_mcause  = csr_wen && (csr_waddr == CSR_MCAUSE);
    assign wr_mcycle  = csr_wen && (csr_waddr == CSR_MCYCLE);
    assign wr_mcycleh = csr_wen && (csr_waddr == CSR_MCYCLEH);

    // Per-register priority: trap, then mret, then the software write.
    always_comb begin
        mstatus_d = mstatus_q;
        if (trap_valid) begin
            mstatus_d = mstatus_on_trap(mstatus_q);
        end else if (mret_valid) begin
            mstatus_d = mstatus_on_mret(mstatus_q);
        end else if (wr_mstatus) begin
            mstatus_d = mstatus_force_mpp((mstatus_q & ~MSTATUS_WMASK) |
                                          (csr_wdata & MSTATUS_WMASK));
        end
    end

    always_comb begin
        mepc_d   = mepc_q;
        mcause_d = mcause_q;
        if (trap_valid) begin
            mepc_d   = trap_pc & ~32'h3;
            mcause_d = trap_cause;
        end else begin
            if (wr_mepc) begin
                mepc_d = csr_wdata & ~32'h3;
            end
            if (wr_mcause) begin
                mcause_d = csr_wdata;
            end
        end
    end

    // Neither trap nor mret touches mtvec, so its write always lands.
    always_comb begin
        mtvec_d = mtvec_q;
        if (wr_mtvec) begin
            mtvec_d = csr_wdata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mstatus_q <= MSTATUS_RV;
            mtvec_q   <= 32'h0;
            mepc_q    <= 32'h0;
            mcause_q  <= 32'h0;
        end else begin
            mstatus_q <= mstatus_d;
            mtvec_q   <= mtvec_d;
            mepc_q    <= mepc_d;
            mcause_q  <= mcause_d;
        end
    end

    ysyx_23060203_csr_cnt64 u_mcycle (
        .clock    (clock),
        .reset    (reset),
        .wen_lo_i (wr_mcycle),
        .wen_hi_i (wr_mcycleh),
        .wdata_i  (csr_wdata),
        .cnt_o    (mcycle)
    );

    always_comb begin
        csr_rdata = 32'h0;
        unique case (csr_raddr)
            CSR_MSTATUS:   csr_rdata = mstatus_q;
            CSR_MTVEC:     csr_rdata = mtvec_q;
            CSR_MEPC:      csr_rdata = mepc_q;
            CSR_MCAUSE:    csr_rdata = mcause_q;
            CSR_MCYCLE:    csr_rdata = mcycle[31:0];
            CSR_MCYCLEH:   csr_rdata = mcycle[63:32];
            CSR_MVENDORID: csr_rdata = MVENDORID;
            CSR_MARCHID:   csr_rdata = MARCHID;
            default:       csr_rdata = 32'h0;
        endcase
    end

    assign mtvec_o = mtvec_q;
    assign mepc_o  = mepc_q;

    // The pipeline must never commit a trap and an mret together.
    a_trap_mret_excl: assert property (
        @(posedge clock) disable iff (!reset) !(trap_valid && mret_valid)
    );

endmodule

// File: tb/tb_ysyx_23060203_csr_file.sv
`timescale 1ns/1ps
module tb_ysyx_23060203_csr_file;

    logic        clock = 1'b0;
    logic        reset;
    logic        csr_wen;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic        trap_valid;
    logic [31:0] trap_pc;
    logic [31:0] trap_cause;
    logic        mret_valid;
    logic [31:0] mtvec_o;
    logic [31:0] mepc_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp;
    logic [31:0] got;

    always #5 clock = ~clock;

    ysyx_23060203_csr_file dut (
        .clock      (clock),
        .reset      (reset),
        .csr_wen    (csr_wen),
        .csr_waddr  (csr_waddr),
        .csr_wdata  (csr_wdata),
        .csr_raddr  (csr_raddr),
        .csr_rdata  (csr_rdata),
        .trap_valid (trap_valid),
        .trap_pc    (trap_pc),
        .trap_cause (trap_cause),
        .mret_valid (mret_valid),
        .mtvec_o    (mtvec_o),
        .mepc_o     (mepc_o)
    );

    task automatic rd(input logic [11:0] a, output logic [31:0] d);
        csr_raddr = a;
        #1;
        d = csr_rdata;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        csr_wen   = 1'b1;
        csr_waddr = a;
        csr_wdata = d;
    endtask

    task automatic test_reset;
        reset = 1'b0; csr_wen = 1'b0; csr_waddr = 12'h0; csr_wdata = 32'h0;
        csr_raddr = 12'h0; trap_valid = 1'b0; trap_pc = 32'h0; trap_cause = 32'h0;
        mret_valid = 1'b0;
        @(negedge clock); @(negedge clock);
        exp_q.push_back(32'h0000_1800); exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);         exp_q.push_back(32'h0);
        rd(12'h300, got); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL rst_mstatus got=%h exp=%h", got, exp); end
        exp = exp_q.pop_front(); n_checks++;
        if (mtvec_o !== exp) begin n_fail++; $display("FAIL rst_mtvec got=%h exp=%h", mtvec_o, exp); end
        exp = exp_q.pop_front(); n_checks++;
        if (mepc_o !== exp) begin n_fail++; $display("FAIL rst_mepc got=%h exp=%h", mepc_o, exp); end
        rd(12'hB00, got); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL rst_mcycle got=%h exp=%h", got, exp); end
        reset = 1'b1;
    endtask

    task automatic test_rw;
        @(negedge clock);
        wr(12'h305, 32'h8000_0100);
        exp_q.push_back(32'h0);   // old value seen in the write cycle
        rd(12'h305, got); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL mtvec_same_cycle got=%h exp=%h", got, exp); end
        @(negedge clock);
        wr(12'h300, 32'hFFFF_FFFF);
        exp_q.push_back(32'h8000_0100); exp_q.push_back(32'h8000_0100);
        rd(12'h305, got); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL mtvec_next_cycle got=%h exp=%h", got, exp); end
        exp = exp_q.pop_front(); n_checks++;
        if (mtvec_o !== exp) begin n_fail++; $display("FAIL mtvec_o got=%h exp=%h", mtvec_o, exp); end
        @(negedge clock);
        wr(12'h341, 32'h0000_1237);
        exp_q.push_back(32'h0000_1888);
        rd(12'h300, got); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL mstatus_mask got=%h exp=%h", got, exp); end
        @(negedge clock);
        wr(12'h300, 32'h0);
        exp_q.push_back(32'h0000_1234); exp_q.push_back(32'h0000_1234);
        rd(12'h341, got); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL mepc_align got=%h exp=%h", got, exp); end
        exp = exp_q.pop_front(); n_checks++;
        if (mepc_o !== exp) begin n_fail++; $display("FAIL mepc_o got=%h exp=%h", mepc_o, exp); end
        @(negedge clock);
        csr_wen = 1'b0;
        exp_q.push_back(32'h0000_1800);
        rd(12'h300, got); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL mstatus_mpp_forced got=%h exp=%h", got, exp); end
    endtask

    task automatic test_ro_drop;
        @(negedge clock); wr(12'h000, 32'hFFFF_FFFF);
        @(negedge clock); wr(12'hF11, 32'h0);
        @(negedge clock); wr(12'hF12, 32'h0);
        @(negedge clock); csr_wen = 1'b0;
        exp_q.push_back(32'h7973_7978); exp_q.push_back(32'h015F_DEEB);
        exp_q.push_back(32'h0);         exp_q.push_back(32'h8000_0100);
        rd(12'hF11, got); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL mvendorid got=%h exp=%h", got, exp); end
        rd(12'hF12, got); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL marchid got=%h exp=%h", got, exp); end
        rd(12'h000, got); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL addr0_read got=%h exp=%h", got, exp); end
        exp = exp_q.pop_front(); n_checks++;
        if (mtvec_o !== exp) begin n_fail++; $display("FAIL mtvec_untouched got=%h exp=%h", mtvec_o, exp); end
        @(negedge clock);
        exp_q.push_back(32'h0); exp_q.push_back(32'h0000_1800);
        rd(12'h344, got); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL unimpl_read got=%h exp=%h", got, exp); end
        rd(12'h300, got); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL mstatus_untouched got=%h exp=%h", got, exp); end
    endtask

    task automatic test_trap_mret;
        @(negedge clock); wr(12'h300, 32'h0000_0008);
        @(negedge clock); csr_wen = 1'b0;
        exp_q.push_back(32'h0000_1808);
        rd(12'h300, got); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL mie_set got=%h exp=%h", got, exp); end
        trap_valid = 1'b1; trap_pc = 32'h8000_0024; trap_cause = 32'd11;
        @(negedge clock);
        trap_valid = 1'b0;
        exp_q.push_back(32'h8000_0024); exp_q.push_back(32'd11);
        exp_q.push_back(32'h0000_1880); exp_q.push_back(32'h8000_0024);
        rd(12'h341, got); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL trap_mepc got=%h exp=%h", got, exp); end
        rd(12'h342, got); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL trap_mcause got=%h exp=%h", got, exp); end
        rd(12'h300, got); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL trap_mstatus got=%h exp=%h", got, exp); end
        exp = exp_q.pop_front(); n_checks++;
        if (mepc_o !== exp) begin n_fail++; $display("FAIL trap_mepc_o got=%h exp=%h", mepc_o, exp); end
        mret_valid = 1'b1;
        @(negedge clock);
        mret_valid = 1'b0;
        exp_q.push_back(32'h0000_1888);
        rd(12'h300, got); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL mret_mstatus got=%h exp=%h", got, exp); end
    endtask

    task automatic test_mcycle;
        @(negedge clock); wr(12'hB80, 32'd5);
        @(negedge clock); wr(12'hB00, 32'hFFFF_FFFF);
        exp_q.push_back(32'd5);
        rd(12'hB80, got); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL mcycleh_write got=%h exp=%h", got, exp); end
        @(negedge clock); csr_wen = 1'b0;
        exp_q.push_back(32'hFFFF_FFFF); exp_q.push_back(32'd5);
        rd(12'hB00, got); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL mcycle_write_no_inc got=%h exp=%h", got, exp); end
        rd(12'hB80, got); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL mcycleh_hold got=%h exp=%h", got, exp); end
        @(negedge clock); wr(12'hB00, 32'hFFFF_FFFF);
        exp_q.push_back(32'h0); exp_q.push_back(32'd6);
        rd(12'hB00, got); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL mcycle_lo_wrap got=%h exp=%h", got, exp); end
        rd(12'hB80, got); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL mcycle_carry got=%h exp=%h", got, exp); end
        @(negedge clock); wr(12'hB80, 32'd7);
        @(negedge clock); csr_wen = 1'b0;
        exp_q.push_back(32'h0); exp_q.push_back(32'd7);
        rd(12'hB00, got); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL mcycle_lo_inc_on_hi_wr got=%h exp=%h", got, exp); end
        rd(12'hB80, got); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL mcycleh_no_carry got=%h exp=%h", got, exp); end
        @(negedge clock); wr(12'hB80, 32'hFFFF_FFFF);
        @(negedge clock); wr(12'hB00, 32'hFFFF_FFFF);
        @(negedge clock); csr_wen = 1'b0;
        @(negedge clock);
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        rd(12'hB00, got); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL mcycle64_wrap_lo got=%h exp=%h", got, exp); end
        rd(12'hB80, got); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL mcycle64_wrap_hi got=%h exp=%h", got, exp); end
    endtask

    task automatic test_trap_priority;
        @(negedge clock);
        wr(12'h341, 32'h0000_1234);
        trap_valid = 1'b1; trap_pc = 32'h8000_0102; trap_cause = 32'd2;
        @(negedge clock);
        wr(12'h305, 32'h0000_2000);
        trap_pc = 32'h8000_0200; trap_cause = 32'd5;
        exp_q.push_back(32'h8000_0100);
        rd(12'h341, got); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL trap_over_mepc_wr got=%h exp=%h", got, exp); end
        @(negedge clock);
        csr_wen = 1'b0; trap_valid = 1'b0;
        exp_q.push_back(32'h0000_2000); exp_q.push_back(32'h8000_0200);
        exp_q.push_back(32'd5);         exp_q.push_back(32'h0000_1800);
        exp = exp_q.pop_front(); n_checks++;
        if (mtvec_o !== exp) begin n_fail++; $display("FAIL trap_plus_mtvec_wr got=%h exp=%h", mtvec_o, exp); end
        rd(12'h341, got); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL trap2_mepc got=%h exp=%h", got, exp); end
        rd(12'h342, got); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL trap2_mcause got=%h exp=%h", got, exp); end
        rd(12'h300, got); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL trap2_mstatus got=%h exp=%h", got, exp); end
    endtask

    task automatic test_reset_midrun;
        @(negedge clock);
        wr(12'h305, 32'h0000_0055);
        reset = 1'b0;
        exp_q.push_back(32'h0000_1800); exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);         exp_q.push_back(32'h0);
        rd(12'h300, got); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL mid_rst_mstatus got=%h exp=%h", got, exp); end
        exp = exp_q.pop_front(); n_checks++;
        if (mtvec_o !== exp) begin n_fail++; $display("FAIL mid_rst_mtvec got=%h exp=%h", mtvec_o, exp); end
        exp = exp_q.pop_front(); n_checks++;
        if (mepc_o !== exp) begin n_fail++; $display("FAIL mid_rst_mepc got=%h exp=%h", mepc_o, exp); end
        rd(12'hB80, got); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL mid_rst_mcycleh got=%h exp=%h", got, exp); end
        @(negedge clock);
        reset = 1'b1; csr_wen = 1'b0;
        exp_q.push_back(32'h0);
        rd(12'h305, got); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL mid_rst_write_lost got=%h exp=%h", got, exp); end
        @(negedge clock);
        exp_q.push_back(32'd1);
        rd(12'hB00, got); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL mcycle_after_rst got=%h exp=%h", got, exp); end
    endtask

    initial begin
        test_reset;
        test_rw;
        test_ro_drop;
        test_trap_mret;
        test_mcycle;
        test_trap_priority;
        test_reset_midrun;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
